fabric_ccff_cfg_loader: RTL and testbench

- Configuration controller for one fabric logic element's configuration flip-flop (CCFF) chain. The chain runs frac_logic → fabric_out muxes → ff D-muxes.
- Accepts bitstream words over a valid/ready interface and serialises them onto ccff_head, one bit per enabled prog_clk cycle.
- Optionally re-circulates the loaded image to verify it against ccff_tail.
- Sits between the tile-level bitstream source and the chain; the chain advances only on cycles where shift_en is high.

---
 rtl/fabric_ccff_cfg_loader.sv | 160 ++++++++++++++++
 tb/tb_fabric_ccff_cfg_loader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_ccff_cfg_loader.sv
// Bitstream loader for one logic element's CCFF chain: serialises words onto
// ccff_head and can re-circulate the loaded image to check it against ccff_tail.
module fabric_ccff_cfg_loader #(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              verify_en,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              ccff_tail,
    output logic              ccff_head,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int BC_W = $clog2(WORD_W + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_VERIFY = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    localparam logic [BC_W-1:0]  WORD_BITS = BC_W'(WORD_W);
    localparam logic [BC_W-1:0]  WORD_ONE  = BC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);

    logic [2:0]           state_q, state_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic [BC_W-1:0]      word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]     bit_count_q, bit_count_d;
    logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
    logic                 verify_q, verify_d;
    logic                 mismatch_q, mismatch_d;

    logic                 shift_c;
    logic                 head_c;
    logic                 ready_c;
    logic                 tail_bad;

    // word_cnt_q holds the number of buffered bits still to shift; zero means
    // the buffer is empty and a new word may be accepted.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        word_cnt_d  = word_cnt_q;
        bit_count_d = bit_count_q;
        shadow_d    = shadow_q;
        verify_d    = verify_q;
        mismatch_d  = mismatch_q;
        shift_c     = 1'b0;
        head_c      = 1'b0;
        ready_c     = 1'b0;
        tail_bad    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d     = S_LOAD;
                    verify_d    = verify_en;
                    bit_count_d = '0;
                    mismatch_d  = 1'b0;
                    word_cnt_d  = '0;
                end
            end

            S_LOAD: begin
                if (word_cnt_q == '0) begin
                    ready_c = 1'b1;
                    if (cfg_valid) begin
                        word_d     = cfg_data;
                        word_cnt_d = WORD_BITS;
                    end
                end else begin
                    shift_c                = 1'b1;
                    head_c                 = word_q[WORD_W-1];
                    shadow_d[bit_count_q]  = word_q[WORD_W-1];
                    bit_count_d            = bit_count_q + CNT_ONE;
                    word_d                 = word_q << 1;
                    word_cnt_d             = word_cnt_q - WORD_ONE;
                    // The final word may overhang the chain; its tail bits are dropped.
                    if (bit_count_q == LAST_BIT) begin
                        word_cnt_d = '0;
                        if (verify_q) begin
                            state_d     = S_VERIFY;
                            bit_count_d = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end

            S_VERIFY: begin
                shift_c     = 1'b1;
                head_c      = shadow_q[bit_count_q];
                tail_bad    = (ccff_tail != shadow_q[bit_count_q]);
                bit_count_d = bit_count_q + CNT_ONE;
                if (tail_bad) begin
                    mismatch_d = 1'b1;
                end
                if (bit_count_q == LAST_BIT) begin
                    state_d = (mismatch_q || tail_bad) ? S_ERROR : S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d     = S_IDLE;
            word_cnt_d  = '0;
            bit_count_d = '0;
            mismatch_d  = 1'b0;
        end
    end

    // All control state resets asynchronously so shifting stops the moment
    // prog_reset rises.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            word_cnt_q  <= '0;
            bit_count_q <= '0;
            shadow_q    <= '0;
            verify_q    <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            word_cnt_q  <= word_cnt_d;
            bit_count_q <= bit_count_d;
            shadow_q    <= shadow_d;
            verify_q    <= verify_d;
            mismatch_q  <= mismatch_d;
        end
    end

    assign cfg_ready = ready_c;
    assign shift_en  = shift_c;
    assign ccff_head = head_c;
    assign busy      = (state_q == S_LOAD) || (state_q == S_VERIFY);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_fabric_ccff_cfg_loader.sv
// Directed bench for fabric_ccff_cfg_loader with a 20-bit behavioural CCFF chain
// attached between ccff_head and ccff_tail.
module tb_fabric_ccff_cfg_loader;

    localparam logic [19:0] IMAGE = 20'b1010_0101_0011_1100_1111;

    logic       prog_clk = 1'b0;
    logic       prog_reset;
    logic       start;
    logic       verify_en;
    logic       abort;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       ccff_tail;
    logic       ccff_head;
    logic       shift_en;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] bit_count;

    int checkCount = 0;
    int passCount  = 0;
    logic stimTimeout = 1'b0;

    logic [19:0] chainQ   = '0;
    logic [63:0] headLog  = '0;
    int          pulseCnt = 0;
    logic        corrupt  = 1'b0;

    fabric_ccff_cfg_loader #(
        .CHAIN_LEN(20),
        .WORD_W(8)
    ) dut (
        .prog_clk(prog_clk),
        .prog_reset(prog_reset),
        .start(start),
        .verify_en(verify_en),
        .abort(abort),
        .cfg_data(cfg_data),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .ccff_tail(ccff_tail),
        .ccff_head(ccff_head),
        .shift_en(shift_en),
        .busy(busy),
        .done(done),
        .error(error),
        .bit_count(bit_count)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model; the corrupt flag inverts what the chain presents at verify step 7.
    assign ccff_tail = chainQ[19] ^ (corrupt && (pulseCnt == 27));

    always @(posedge prog_clk) begin
        if (shift_en) begin
            chainQ <= {chainQ[18:0], ccff_head};
            if (pulseCnt < 64) headLog[pulseCnt] <= ccff_head;
        end
        if (start && !busy && !prog_reset) pulseCnt <= 0;
        else if (shift_en) pulseCnt <= pulseCnt + 1;
    end

    function automatic logic [19:0] logSlice(input int base);
        logic [19:0] r;
        for (int i = 0; i < 20; i++) r[19-i] = headLog[base+i];
        return r;
    endfunction

    task automatic doStart(input logic v);
        @(negedge prog_clk);
        start = 1'b1;
        verify_en = v;
        @(negedge prog_clk);
        start = 1'b0;
        verify_en = 1'b0;
    endtask

    task automatic sendWord(input logic [7:0] w);
        int t;
        t = 0;
        cfg_data = w;
        cfg_valid = 1'b1;
        while (!cfg_ready && t < 100) begin
            @(negedge prog_clk);
            t++;
        end
        if (t >= 100) stimTimeout = 1'b1;
        @(negedge prog_clk);
        cfg_valid = 1'b0;
    endtask

    task automatic waitNotBusy();
        int t;
        t = 0;
        while (busy && t < 200) begin
            @(negedge prog_clk);
            t++;
        end
        if (t >= 200) stimTimeout = 1'b1;
    endtask

    task automatic test_reset();
        prog_reset = 1'b1;
        start = 0; verify_en = 0; abort = 0; cfg_data = '0; cfg_valid = 0;
        #3;
        checkCount++;
        if ({cfg_ready, ccff_head, shift_en, busy, done, error, bit_count} !== 11'd0)
            $display("[TB] FAIL reset_outputs: got %b expected 0",
                     {cfg_ready, ccff_head, shift_en, busy, done, error, bit_count});
        else passCount++;
        repeat (2) @(negedge prog_clk);
        prog_reset = 1'b0;
        @(negedge prog_clk);
        checkCount++;
        if (busy !== 1'b0 || shift_en !== 1'b0)
            $display("[TB] FAIL idle_after_reset: busy %b shift_en %b expected 0 0", busy, shift_en);
        else passCount++;
    endtask

    task automatic test_load_no_verify();
        doStart(1'b0);
        sendWord(8'hA5);
        sendWord(8'h3C);
        sendWord(8'hF0);
        checkCount++;
        if (cfg_ready !== 1'b0) $display("[TB] FAIL ready_after_third: got %b expected 0", cfg_ready);
        else passCount++;
        waitNotBusy();
        checkCount++;
        if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0)
            $display("[TB] FAIL load_status: done %b busy %b error %b expected 1 0 0", done, busy, error);
        else passCount++;
        checkCount++;
        if (pulseCnt !== 20) $display("[TB] FAIL load_pulses: got %0d expected 20", pulseCnt);
        else passCount++;
        checkCount++;
        if (logSlice(0) !== IMAGE) $display("[TB] FAIL load_head_seq: got %b expected %b", logSlice(0), IMAGE);
        else passCount++;
        checkCount++;
        if (chainQ !== IMAGE) $display("[TB] FAIL load_chain: got %b expected %b", chainQ, IMAGE);
        else passCount++;
        checkCount++;
        if (bit_count !== 5'd20 || cfg_ready !== 1'b0 || shift_en !== 1'b0 || ccff_head !== 1'b0)
            $display("[TB] FAIL done_outputs: bit_count %0d ready %b shift %b head %b expected 20 0 0 0",
                     bit_count, cfg_ready, shift_en, ccff_head);
        else passCount++;
    endtask

    task automatic test_load_verify();
        doStart(1'b1);
        sendWord(8'hA5);
        sendWord(8'h3C);
        sendWord(8'hF0);
        waitNotBusy();
        checkCount++;
        if (done !== 1'b1 || error !== 1'b0)
            $display("[TB] FAIL verify_ok_status: done %b error %b expected 1 0", done, error);
        else passCount++;
        checkCount++;
        if (pulseCnt !== 40) $display("[TB] FAIL verify_ok_pulses: got %0d expected 40", pulseCnt);
        else passCount++;
        checkCount++;
        if (logSlice(20) !== IMAGE) $display("[TB] FAIL verify_head_seq: got %b expected %b", logSlice(20), IMAGE);
        else passCount++;
        checkCount++;
        if (chainQ !== IMAGE) $display("[TB] FAIL verify_ok_chain: got %b expected %b", chainQ, IMAGE);
        else passCount++;
    endtask

    task automatic test_verify_error();
        corrupt = 1'b1;
        doStart(1'b1);
        sendWord(8'hA5);
        sendWord(8'h3C);
        sendWord(8'hF0);
        waitNotBusy();
        corrupt = 1'b0;
        checkCount++;
        if (error !== 1'b1 || done !== 1'b0)
            $display("[TB] FAIL verify_err_status: error %b done %b expected 1 0", error, done);
        else passCount++;
        checkCount++;
        if (pulseCnt !== 40) $display("[TB] FAIL verify_err_pulses: got %0d expected 40", pulseCnt);
        else passCount++;
        checkCount++;
        if (chainQ !== IMAGE) $display("[TB] FAIL verify_err_chain: got %b expected %b", chainQ, IMAGE);
        else passCount++;
    endtask

    task automatic test_bubble();
        int bad;
        bad = 0;
        doStart(1'b0);
        sendWord(8'hA5);
        repeat (8) @(negedge prog_clk);
        for (int i = 0; i < 5; i++) begin
            if (shift_en !== 1'b0 || bit_count !== 5'd8) bad++;
            @(negedge prog_clk);
        end
        checkCount++;
        if (bad !== 0) $display("[TB] FAIL bubble_hold: got %0d bad cycles expected 0", bad);
        else passCount++;
        sendWord(8'h3C);
        sendWord(8'hF0);
        waitNotBusy();
        checkCount++;
        if (done !== 1'b1 || pulseCnt !== 20 || chainQ !== IMAGE)
            $display("[TB] FAIL bubble_result: done %b pulses %0d chain %b expected 1 20 %b",
                     done, pulseCnt, chainQ, IMAGE);
        else passCount++;
    endtask

    task automatic test_abort();
        int t;
        doStart(1'b0);
        sendWord(8'hA5);
        sendWord(8'h3C);
        t = 0;
        while (bit_count !== 5'd11 && t < 50) begin
            @(negedge prog_clk);
            t++;
        end
        if (t >= 50) stimTimeout = 1'b1;
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        checkCount++;
        if (busy !== 1'b0 || shift_en !== 1'b0 || bit_count !== 5'd0 || done !== 1'b0 || cfg_ready !== 1'b0)
            $display("[TB] FAIL abort_state: busy %b shift %b count %0d done %b ready %b expected all 0",
                     busy, shift_en, bit_count, done, cfg_ready);
        else passCount++;
        repeat (5) @(negedge prog_clk);
        checkCount++;
        if (pulseCnt !== 12) $display("[TB] FAIL abort_pulses: got %0d expected 12", pulseCnt);
        else passCount++;
        doStart(1'b0);
        sendWord(8'hA5);
        sendWord(8'h3C);
        sendWord(8'hF0);
        waitNotBusy();
        checkCount++;
        if (done !== 1'b1 || chainQ !== IMAGE)
            $display("[TB] FAIL abort_reload: done %b chain %b expected 1 %b", done, chainQ, IMAGE);
        else passCount++;
    endtask

    task automatic test_reset_mid_verify();
        int t;
        doStart(1'b1);
        sendWord(8'hA5);
        sendWord(8'h3C);
        sendWord(8'hF0);
        t = 0;
        while (pulseCnt < 25 && t < 100) begin
            @(negedge prog_clk);
            t++;
        end
        if (t >= 100) stimTimeout = 1'b1;
        prog_reset = 1'b1;
        #1;
        checkCount++;
        if ({cfg_ready, ccff_head, shift_en, busy, done, error, bit_count} !== 11'd0)
            $display("[TB] FAIL reset_mid_verify: got %b expected 0",
                     {cfg_ready, ccff_head, shift_en, busy, done, error, bit_count});
        else passCount++;
        repeat (3) @(negedge prog_clk);
        prog_reset = 1'b0;
        repeat (3) @(negedge prog_clk);
        checkCount++;
        if (pulseCnt !== 25 || busy !== 1'b0)
            $display("[TB] FAIL reset_no_shift: pulses %0d busy %b expected 25 0", pulseCnt, busy);
        else passCount++;
    endtask

    task automatic test_busy_start();
        doStart(1'b0);
        sendWord(8'hA5);
        repeat (3) @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        checkCount++;
        if (busy !== 1'b1 || bit_count !== 5'd4 || shift_en !== 1'b1)
            $display("[TB] FAIL busy_start: busy %b count %0d shift %b expected 1 4 1", busy, bit_count, shift_en);
        else passCount++;
        sendWord(8'h3C);
        sendWord(8'hF0);
        waitNotBusy();
        checkCount++;
        if (done !== 1'b1 || pulseCnt !== 20 || chainQ !== IMAGE)
            $display("[TB] FAIL busy_start_result: done %b pulses %0d chain %b expected 1 20 %b",
                     done, pulseCnt, chainQ, IMAGE);
        else passCount++;
    endtask

    task automatic test_abort_start();
        @(negedge prog_clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        abort = 1'b0;
        checkCount++;
        if (busy !== 1'b0 || done !== 1'b0 || bit_count !== 5'd0 || cfg_ready !== 1'b0)
            $display("[TB] FAIL abort_start: busy %b done %b count %0d ready %b expected 0 0 0 0",
                     busy, done, bit_count, cfg_ready);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_load_no_verify();
        test_load_verify();
        test_verify_error();
        test_bubble();
        test_abort();
        test_reset_mid_verify();
        test_busy_start();
        test_abort_start();
        checkCount++;
        if (stimTimeout !== 1'b0) $display("[TB] FAIL stimulus_timeout: got %b expected 0", stimTimeout);
        else passCount++;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
